// File: rtl/digit_entry_buffer.sv
// ---------------------------------------------------------------------------
// digit_entry_buffer
//
// Sits behind the keypad scanning driver. It turns the driver's repeated
// per-scan "key seen" strobes into one accepted action per physical press,
// keeps an N_DIG-digit hex entry buffer for the display, and commits the
// entered value when Enter rises.
//
// Key codes: 0x0-0xD push a digit, 0xE is backspace, 0xF clears the entry.
//
// Optional build macro:
//   DIGIT_ENTRY_MASK_EN - password masking of o_disp. Valid nibbles read 0xF,
//                         except nibble 0, which shows its real digit for
//                         MASK_HOLD cycles after each push/backspace accept.
//                         Without the macro o_disp is the raw buffer and no
//                         hold counter exists.
//
// Ports:
//   i_clk            system clock (100 Hz, shared with the keypad driver)
//   i_rst            synchronous active-high reset
//   i_digito         key code, values >= 16 mean "no key"
//   i_cambio_digito  high in any cycle where the scan saw a pressed key
//   i_enter_sync     synchronised Enter level
//   o_disp           entry buffer for the display, nibble 0 is newest
//   o_disp_valid     bit i set when nibble i holds an entered digit
//   o_n_digits       number of digits currently entered
//   o_value          last committed value (never masked)
//   o_value_valid    one-cycle pulse when o_value updates
//   o_overflow       sticky, set when a push hits a full buffer
//
// Debounce FSM
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   IDLE     | no key qualified, waiting for the first strobe
//   ARM      | candidate latched, counting matching strobes
//   WAIT_REL | key accepted, waiting for RELEASE_CYCLES strobe-free cycles
// ---------------------------------------------------------------------------
module digit_entry_buffer #(
    parameter int N_DIG          = 4,
    parameter int DEB_PRESSES    = 2,
    parameter int RELEASE_CYCLES = 8,
    parameter int MASK_HOLD      = 100
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [4:0]                   i_digito,
    input  logic                         i_cambio_digito,
    input  logic                         i_enter_sync,
    output logic [4*N_DIG-1:0]           o_disp,
    output logic [N_DIG-1:0]             o_disp_valid,
    output logic [$clog2(N_DIG+1)-1:0]   o_n_digits,
    output logic [4*N_DIG-1:0]           o_value,
    output logic                         o_value_valid,
    output logic                         o_overflow
);

    localparam int NW = $clog2(N_DIG + 1);
    localparam int GW = $clog2(RELEASE_CYCLES + 1);
    localparam int HW = $clog2(DEB_PRESSES + 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ARM      = 2'd1,
        S_WAIT_REL = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [3:0]    r_cand;
    logic [HW-1:0] r_hits;
    logic [GW-1:0] r_gap;

    logic          w_strobe;
    logic          w_match;
    logic [GW-1:0] w_gap_inc;
    logic [HW-1:0] w_hits_inc;
    logic          w_gap_done;
    logic          w_hits_done;

    logic          w_accept;
    logic [3:0]    w_accept_code;

    logic [4*N_DIG-1:0] r_disp;
    logic [N_DIG-1:0]   r_valid;
    logic [NW-1:0]      r_n;
    logic [4*N_DIG-1:0] r_value;
    logic               r_value_valid;
    logic               r_overflow;
    logic               r_enter_d;

    logic               w_enter_rise;
    logic               w_commit;
    logic               w_act;

    // A strobe needs a real key code; "seen" with code >= 16 is ignored.
    assign w_strobe = i_cambio_digito && !i_digito[4];
    assign w_match  = w_strobe && (i_digito[3:0] == r_cand);

    // Saturating increments so long idle stretches never wrap the counters.
    assign w_gap_inc   = (r_gap == GW'(RELEASE_CYCLES)) ? r_gap : r_gap + GW'(1);
    assign w_hits_inc  = (r_hits == HW'(DEB_PRESSES)) ? r_hits : r_hits + HW'(1);
    assign w_gap_done  = (w_gap_inc == GW'(RELEASE_CYCLES));
    assign w_hits_done = (w_hits_inc == HW'(DEB_PRESSES));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_strobe) begin
                    w_state_nxt = (DEB_PRESSES <= 1) ? S_WAIT_REL : S_ARM;
                end
            end
            S_ARM: begin
                if (w_match) begin
                    if (w_hits_done) begin
                        w_state_nxt = S_WAIT_REL;
                    end
                end else if (w_strobe) begin
                    // different key: bounce or two keys together
                    w_state_nxt = S_IDLE;
                end else if (w_gap_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT_REL: begin
                if (!w_strobe && w_gap_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (accept strobe and the accepted code)
    // ------------------------------------------------------------------
    always_comb begin
        w_accept      = 1'b0;
        w_accept_code = r_cand;
        case (r_state)
            S_IDLE: begin
                if (w_strobe && (DEB_PRESSES <= 1)) begin
                    w_accept      = 1'b1;
                    w_accept_code = i_digito[3:0];
                end
            end
            S_ARM: begin
                if (w_match && w_hits_done) begin
                    w_accept = 1'b1;
                end
            end
            default: begin
                w_accept = 1'b0;
            end
        endcase
    end

    // Candidate, hit and gap counters that accompany the FSM.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cand <= '0;
            r_hits <= '0;
            r_gap  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_strobe) begin
                        r_cand <= i_digito[3:0];
                        r_hits <= HW'(1);
                        r_gap  <= '0;
                    end
                end
                S_ARM: begin
                    if (w_match) begin
                        r_hits <= w_hits_inc;
                        r_gap  <= '0;
                    end else if (!w_strobe) begin
                        r_gap <= w_gap_inc;
                    end
                end
                S_WAIT_REL: begin
                    if (w_strobe) begin
                        r_gap <= '0;
                    end else begin
                        r_gap <= w_gap_inc;
                    end
                end
                default: begin
                    r_gap <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Entry buffer and commit
    // ------------------------------------------------------------------
    assign w_enter_rise = i_enter_sync && !r_enter_d;
    assign w_commit     = w_enter_rise && (r_n != '0);
    // An Enter edge in the accepting cycle swallows the key; the FSM still
    // moves to WAIT_REL so the held key is not taken again.
    assign w_act        = w_accept && !w_enter_rise;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_disp        <= '0;
            r_valid       <= '0;
            r_n           <= '0;
            r_value       <= '0;
            r_value_valid <= 1'b0;
            r_overflow    <= 1'b0;
            r_enter_d     <= 1'b0;
        end else begin
            r_enter_d     <= i_enter_sync;
            r_value_valid <= 1'b0;
            if (w_commit) begin
                r_value       <= r_disp;
                r_value_valid <= 1'b1;
                r_disp        <= '0;
                r_valid       <= '0;
                r_n           <= '0;
                r_overflow    <= 1'b0;
            end else if (w_act) begin
                if (w_accept_code <= 4'hD) begin
                    if (r_n < NW'(N_DIG)) begin
                        r_disp  <= (r_disp << 4) | {{(4*N_DIG-4){1'b0}}, w_accept_code};
                        r_valid <= (r_valid << 1) | N_DIG'(1);
                        r_n     <= r_n + NW'(1);
                    end else begin
                        r_overflow <= 1'b1;
                    end
                end else if (w_accept_code == 4'hE) begin
                    if (r_n != '0) begin
                        r_disp  <= r_disp >> 4;
                        r_valid <= r_valid >> 1;
                        r_n     <= r_n - NW'(1);
                    end
                end else begin
                    r_disp     <= '0;
                    r_valid    <= '0;
                    r_n        <= '0;
                    r_overflow <= 1'b0;
                end
            end
        end
    end

`ifdef DIGIT_ENTRY_MASK_EN
    localparam int MW = $clog2(MASK_HOLD + 1);

    // Down-counter: nibble 0 is shown in clear while it is non-zero.
    logic [MW-1:0] r_hold;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hold <= '0;
        end else if (w_act && (w_accept_code != 4'hF)) begin
            r_hold <= MW'(MASK_HOLD);
        end else if (r_hold != '0) begin
            r_hold <= r_hold - MW'(1);
        end
    end

    always_comb begin
        o_disp = '0;
        for (int i = 0; i < N_DIG; i++) begin
            if (!r_valid[i]) begin
                o_disp[4*i +: 4] = 4'h0;
            end else if ((i == 0) && (r_hold != '0)) begin
                o_disp[4*i +: 4] = r_disp[4*i +: 4];
            end else begin
                o_disp[4*i +: 4] = 4'hF;
            end
        end
    end
`else
    assign o_disp = r_disp;
`endif

    assign o_disp_valid  = r_valid;
    assign o_n_digits    = r_n;
    assign o_value       = r_value;
    assign o_value_valid = r_value_valid;
    assign o_overflow    = r_overflow;

endmodule

// File: tb/tb_digit_entry_buffer.sv
module tb_digit_entry_buffer;

    localparam int N_DIG = 4;
    localparam int DEB   = 2;
    localparam int REL   = 8;
    localparam int MH    = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        cd;
    logic        en;
    logic [4:0]  dg;
    logic [15:0] disp;
    logic [3:0]  dv;
    logic [2:0]  nd;
    logic [15:0] value;
    logic        vv;
    logic        ovf;

    always #5 clk = ~clk;

    digit_entry_buffer #(
        .N_DIG(N_DIG), .DEB_PRESSES(DEB), .RELEASE_CYCLES(REL), .MASK_HOLD(MH)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_digito(dg), .i_cambio_digito(cd),
        .i_enter_sync(en), .o_disp(disp), .o_disp_valid(dv), .o_n_digits(nd),
        .o_value(value), .o_value_valid(vv), .o_overflow(ovf)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int vv_seen  = 0;

    // Reference model: entered digits as a queue (index 0 = newest).
    int          m_q[$];
    bit          m_ovf;
    logic [15:0] m_value;
    bit          m_vv;
    int          m_cand;     // -1: nothing being qualified
    int          m_hits;
    int          m_quiet;    // consecutive strobe-free cycles
    bit          m_locked;   // key taken, waiting for release
    bit          m_enter_prev;
`ifdef DIGIT_ENTRY_MASK_EN
    int          m_hold;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] m_pack();
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < m_q.size(); i++) v[4*i +: 4] = 4'(m_q[i]);
        return v;
    endfunction

    function automatic logic [15:0] m_disp();
        logic [15:0] d;
        d = '0;
        for (int i = 0; i < m_q.size(); i++) begin
`ifdef DIGIT_ENTRY_MASK_EN
            d[4*i +: 4] = (i == 0 && m_hold > 0) ? 4'(m_q[0]) : 4'hF;
`else
            d[4*i +: 4] = 4'(m_q[i]);
`endif
        end
        return d;
    endfunction

    function automatic void model_update(input bit r, input bit c, input logic [4:0] d, input bit e);
        bit strobe;
        bit rise;
        int acc;
        if (r) begin
            m_q.delete();
            m_ovf = 0; m_value = '0; m_vv = 0;
            m_cand = -1; m_hits = 0; m_quiet = 0; m_locked = 0; m_enter_prev = 0;
`ifdef DIGIT_ENTRY_MASK_EN
            m_hold = 0;
`endif
            return;
        end
        strobe = c && (d < 16);
        acc = -1;
        if (m_locked) begin
            if (strobe) m_quiet = 0;
            else begin
                m_quiet++;
                if (m_quiet >= REL) m_locked = 0;
            end
        end else if (m_cand < 0) begin
            if (strobe) begin
                m_cand = int'(d); m_hits = 1; m_quiet = 0;
                if (m_hits >= DEB) begin
                    acc = m_cand; m_locked = 1; m_cand = -1;
                end
            end
        end else begin
            if (strobe && int'(d) == m_cand) begin
                m_hits++; m_quiet = 0;
                if (m_hits >= DEB) begin
                    acc = m_cand; m_locked = 1; m_cand = -1;
                end
            end else if (strobe) begin
                m_cand = -1;
            end else begin
                m_quiet++;
                if (m_quiet >= REL) m_cand = -1;
            end
        end

        rise = e && !m_enter_prev;
        m_enter_prev = e;
        m_vv = 0;
        if (rise) begin
            acc = -1;
            if (m_q.size() > 0) begin
                m_value = m_pack();
                m_vv = 1;
                m_q.delete();
                m_ovf = 0;
            end
        end
`ifdef DIGIT_ENTRY_MASK_EN
        if (acc >= 0 && acc != 15) m_hold = MH;
        else if (m_hold > 0) m_hold--;
`endif
        if (acc >= 0 && acc <= 13) begin
            if (m_q.size() < N_DIG) m_q.push_front(acc);
            else m_ovf = 1;
        end else if (acc == 14) begin
            if (m_q.size() > 0) void'(m_q.pop_front());
        end else if (acc == 15) begin
            m_q.delete();
            m_ovf = 0;
        end
    endfunction

    task automatic step(input bit r, input bit c, input logic [4:0] d, input bit e);
        logic [3:0] exp_v;
        rst = r; cd = c; dg = d; en = e;
        @(posedge clk);
        model_update(r, c, d, e);
        #1;
        if (vv) vv_seen++;
        exp_v = 4'((1 << m_q.size()) - 1);
        chk("cycle", {disp, dv, nd, value, vv, ovf},
            {m_disp(), exp_v, 3'(m_q.size()), m_value, m_vv, m_ovf});
    endtask

    task automatic idle(input int n, input bit e);
        for (int i = 0; i < n; i++) step(0, 0, 5'd16, e);
    endtask

    task automatic press(input logic [4:0] key, input int hold);
        for (int i = 0; i < hold; i++) step(0, 1, key, 0);
        idle(10, 0);
    endtask

    int key, hl, gp, rr;
    bit ent;

    initial begin
        rst = 1; cd = 0; dg = 5'd16; en = 0;
        step(1, 0, 5'd16, 0);
        step(1, 1, 5'd3, 1);
        chk("rst_disp", disp, 16'h0);
        chk("rst_n", nd, 3'd0);
        chk("rst_vv", vv, 1'b0);
        step(0, 0, 5'd16, 0);

        // strobe every 4th cycle for 40 cycles -> one push
        for (int i = 0; i < 40; i++) step(0, (i % 4) == 0, 5'd5, 0);
        idle(10, 0);
`ifndef DIGIT_ENTRY_MASK_EN
        chk("hold5_disp", disp, 16'h0005);
`endif
        chk("hold5_n", nd, 3'd1);

        // fill and overflow
        press(5'hF, 3);
        press(5'd1, 20); press(5'd2, 20); press(5'd3, 20); press(5'd4, 20); press(5'd7, 20);
`ifndef DIGIT_ENTRY_MASK_EN
        chk("full_disp", disp, 16'h1234);
`endif
        chk("full_n", nd, 3'd4);
        chk("full_ovf", ovf, 1'b1);

        // backspace and clear
        press(5'hF, 3);
        chk("clr_ovf", ovf, 1'b0);
        press(5'd1, 3); press(5'd2, 3); press(5'd3, 3);
        press(5'hE, 3);
`ifndef DIGIT_ENTRY_MASK_EN
        chk("bksp_disp", disp, 16'h0012);
`endif
        chk("bksp_n", nd, 3'd2);
        press(5'hF, 3);
        chk("clr_disp", disp, 16'h0);
        chk("clr_valid", dv, 4'h0);

        // enter held for 5 cycles -> one commit
        press(5'd4, 3); press(5'd2, 3);
        vv_seen = 0;
        idle(5, 1); idle(3, 0);
        chk("enter_pulses", vv_seen, 1);
        chk("enter_value", value, 16'h0042);
        chk("enter_n", nd, 3'd0);
        vv_seen = 0;
        idle(3, 1); idle(3, 0);
        chk("enter_empty_pulses", vv_seen, 0);

        // mismatch aborts ARM; the new key is not latched as candidate
        step(0, 1, 5'd3, 0); step(0, 1, 5'd6, 0); step(0, 1, 5'd6, 0);
        idle(10, 0);
        chk("bounce_n", nd, 3'd0);
        // isolated strobe + 8 quiet cycles -> rejected even if key returns
        step(0, 1, 5'd8, 0); idle(8, 0); step(0, 1, 5'd8, 0);
        idle(10, 0);
        chk("glitch_n", nd, 3'd0);
        // 7 quiet cycles keep ARM alive
        step(0, 1, 5'd9, 0); idle(7, 0); step(0, 1, 5'd9, 0);
        idle(10, 0);
        chk("gap7_n", nd, 3'd1);
        // code >= 16 with cambio is not a strobe
        step(0, 1, 5'd2, 0); step(0, 1, 5'd20, 0); step(0, 1, 5'd2, 0);
        idle(10, 0);
        chk("nokey_n", nd, 3'd2);

        // reset mid-press requalifies the key
        step(0, 1, 5'd5, 0); step(1, 1, 5'd5, 0); step(0, 1, 5'd5, 0);
        idle(10, 0);
        chk("rstmid_n", nd, 3'd0);
        press(5'd5, 2);
        chk("rstmid_again_n", nd, 3'd1);

        // enter rising in the accepting cycle wins
        step(0, 1, 5'd7, 0); step(0, 1, 5'd7, 1);
        for (int i = 0; i < 4; i++) step(0, 1, 5'd7, 1);
        idle(10, 0);
        chk("enter_win_n", nd, 3'd0);
        chk("enter_win_value", value, 16'h0005);

`ifdef DIGIT_ENTRY_MASK_EN
        press(5'd1, 20); press(5'd2, 20);
        chk("mask_live", disp, 16'h00F2);
        idle(100, 0);
        chk("mask_hidden", disp, 16'h00FF);
        idle(2, 1); idle(2, 0);
        chk("mask_value", value, 16'h0012);
`endif

        // randomized presses checked cycle by cycle against the model
        for (int k = 0; k < 80; k++) begin
            key = $urandom_range(0, 15);
            hl  = $urandom_range(1, 6);
            gp  = $urandom_range(0, 12);
            ent = ($urandom_range(0, 5) == 0);
            for (int j = 0; j < hl; j++) begin
                rr = $urandom_range(0, 7);
                if (rr == 0)      step(0, 1, 5'($urandom_range(16, 31)), ent && j == hl - 1);
                else if (rr == 1) step(0, 0, 5'd16, ent && j == hl - 1);
                else              step(0, 1, 5'(key), ent && j == hl - 1);
            end
            for (int j = 0; j < gp; j++) step(0, 0, 5'd16, ent && j == 0);
        end
        idle(12, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
